mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline MEM stage that sits directly upstream of the MEM/WB register.
- Takes the EX-stage result and the instruction word; performs LW/SW through a request/acknowledge data-memory port.
- Registers {IR, read data, ALU result} for the MEM/WB register.
- Stalls upstream stages while a memory access is outstanding; emits bubbles downstream meanwhile.

Parameters:
- BUBBLE_IR, 32'h7000_0000: IR emitted when no valid instruction leaves the stage. Opcode BGE means no register writeback.
- TIMEOUT_CYCLES, 16: BUSY cycles without ack before abort. Used only with MEM_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- valid_i  in  1  EX result valid this cycle.
- IR_i  in  32  instruction word; opcode is IR_i[31:28] (LW=4'b0000, SW=4'b0001).
- alu_i  in  32  ALU result, or effective address for LW/SW.
- store_data_i  in  32  SW write data.
- stall_o  out  1  combinational; upstream holds valid_i/IR_i/alu_i/store_data_i while high.
- mem_req_o  out  1  registered memory request.
- mem_we_o  out  1  registered; 1 = write (SW).
- mem_addr_o  out  32  registered; equals captured alu_i.
- mem_wdata_o  out  32  registered; equals captured store_data_i.
- mem_rdata_i  in  32  read data; sampled in the ack cycle.
- mem_ack_i  in  1  one-cycle completion strobe.
- IR_o  out  32  to MEM/WB IR input.
- data1_o  out  32  to MEM/WB data1: LW read data; 0 for all other instructions.
- data2_o  out  32  to MEM/WB data2: captured alu_i.
- valid_o  out  1  output holds a real instruction.
- mem_err_o  out  1  sticky timeout error.

Behaviour:
- Clock and reset: single clock clk_i; rst_i is synchronous and active-high.
- Reset values:
  - state=IDLE
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0
  - IR_o=BUBBLE_IR, data1_o=0, data2_o=0, valid_o=0
  - mem_err_o=0, timeout counter=0
- is_mem = valid_i & (IR_i[31:28]==LW | IR_i[31:28]==SW).
- stall_o = (IDLE & is_mem) | (BUSY & ~mem_ack_i).
- IDLE, valid_i=0: next edge emits a bubble (IR_o=BUBBLE_IR, data1_o=0, data2_o=0, valid_o=0).
- IDLE, valid non-memory op: next edge emits IR_o=IR_i, data2_o=alu_i, data1_o=0, valid_o=1. Latency 1; no stall.
- IDLE, is_mem: next edge captures IR/alu/store_data, sets mem_req_o=1, mem_we_o=(opcode==SW), drives address and write data, goes to BUSY, and emits a bubble.
- BUSY, no ack: mem_req_o and all mem_* outputs held stable; bubble emitted each cycle.
- BUSY, mem_ack_i=1:
  - next edge emits the captured IR, data2_o=captured alu, valid_o=1.
  - data1_o = mem_rdata_i for LW, 0 for SW.
  - mem_req_o=0, mem_we_o=0; returns to IDLE.
  - stall_o is low in the ack cycle, so upstream advances on the same edge.
- Load latency: accept at cycle T, ack at T+k (k>=1) → IR_o valid from T+k+1.
- mem_ack_i in IDLE: ignored.
- Back-to-back memory ops: the next op is seen in IDLE the cycle after the ack edge. At most one outstanding request.
- rst_i mid-transaction: request abandoned; mem_req_o drops on that edge; a later ack is ignored; outputs go to reset values.
- Output registers update every cycle. MEM/WB clocks unconditionally, so every cycle without a completed instruction must present BUBBLE_IR.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - 8-bit counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack: next edge drops mem_req_o, returns to IDLE, emits a bubble (instruction dropped), and sets mem_err_o=1.
  - mem_err_o stays set until rst_i.
  - An ack in the same cycle as the timeout wins: normal completion, no error.
- Undefined: BUSY waits indefinitely; mem_err_o tied to 0; no counter logic.

Test Plan:
- ADDU IR=32'h3080_0000, alu_i=5, valid_i=1 → next cycle IR_o=32'h3080_0000, data2_o=5, data1_o=0, valid_o=1; stall_o never high.
- LW IR=32'h0100_0000, alu_i=32'h40, ack 3 cycles after mem_req_o rises with mem_rdata_i=32'hCAFE_0001 → mem_addr_o=32'h40, mem_we_o=0; stall_o high 3 cycles plus accept cycle; bubbles meanwhile; then data1_o=32'hCAFE_0001, valid_o=1.
- SW alu_i=32'h80, store_data_i=32'h1234, ack after 1 cycle → mem_we_o=1, mem_wdata_o=32'h1234; output IR=SW, data1_o=0.
- LW then ADDU back-to-back, ack after 2 cycles → ADDU appears on IR_o exactly one cycle after the LW; no duplicated or lost instruction.
- rst_i asserted while BUSY, then ack pulsed in IDLE → mem_req_o=0 after the reset edge; the ack produces no output (IR_o=BUBBLE_IR, valid_o=0).
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, LW never acked → mem_req_o drops after 4 BUSY cycles; mem_err_o=1 and stays set; stall_o low; next ADDU passes normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage: LW/SW over a req/ack data port, feeds MEM/WB
// Optional feature macro: MEM_TIMEOUT_EN (abort a BUSY access after TIMEOUT_CYCLES without ack)

module mem_access_stage #(
    parameter logic [31:0] BUBBLE_IR      = 32'h7000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    input  logic [31:0] IR_i,
    input  logic [31:0] alu_i,
    input  logic [31:0] store_data_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ack_i,
    output logic [31:0] IR_o,
    output logic [31:0] data1_o,
    output logic [31:0] data2_o,
    output logic        valid_o,
    output logic        mem_err_o
);

    localparam logic [3:0] OP_LW = 4'b0000;
    localparam logic [3:0] OP_SW = 4'b0001;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_ir;
    logic [3:0]  w_op;
    logic        w_is_mem;
    logic        w_idle;
    logic        w_busy;
    logic        w_done;
    logic        w_timeout;
    logic        w_abort;

    assign w_op     = IR_i[31:28];
    assign w_is_mem = valid_i & ((w_op == OP_LW) | (w_op == OP_SW));
    assign w_idle   = (r_state == S_IDLE);
    assign w_busy   = (r_state == S_BUSY);
    assign w_done   = w_busy & mem_ack_i;
    // An ack arriving in the timeout cycle takes priority over the abort.
    assign w_abort  = w_busy & ~mem_ack_i & w_timeout;

    assign stall_o  = (w_idle & w_is_mem) | (w_busy & ~mem_ack_i);

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_cnt;
    logic       r_err;

    assign w_timeout = (r_cnt == TO_LAST);
    assign mem_err_o = r_err;

    // Count BUSY cycles without ack; latch a sticky error when an access is aborted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
        end else begin
            if (w_idle & w_is_mem) begin
                r_cnt <= 8'd0;
            end else if (w_busy & ~mem_ack_i) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_abort) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    // Without the watchdog a BUSY access waits for its ack forever.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
    assign w_timeout = 1'b0;
    assign mem_err_o = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: enter BUSY on a memory op, leave on ack or abort.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_is_mem) w_state_nxt = S_BUSY;
            S_BUSY:  if (w_done | w_abort) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Memory port: capture the access on accept, hold it while BUSY, drop the request on completion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= 32'd0;
            mem_wdata_o <= 32'd0;
            r_ir        <= BUBBLE_IR;
        end else if (w_idle & w_is_mem) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= (w_op == OP_SW);
            mem_addr_o  <= alu_i;
            mem_wdata_o <= store_data_i;
            r_ir        <= IR_i;
        end else if (w_done | w_abort) begin
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
        end
    end

    // Output register: every cycle carries either a completed instruction or a bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            IR_o    <= BUBBLE_IR;
            data1_o <= 32'd0;
            data2_o <= 32'd0;
            valid_o <= 1'b0;
        end else if (w_idle & valid_i & ~w_is_mem) begin
            IR_o    <= IR_i;
            data1_o <= 32'd0;
            data2_o <= alu_i;
            valid_o <= 1'b1;
        end else if (w_done) begin
            IR_o    <= r_ir;
            data1_o <= mem_we_o ? 32'd0 : mem_rdata_i;
            data2_o <= mem_addr_o;
            valid_o <= 1'b1;
        end else begin
            IR_o    <= BUBBLE_IR;
            data1_o <= 32'd0;
            data2_o <= 32'd0;
            valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage

module tb_mem_access_stage;

    localparam logic [31:0] BUBBLE = 32'h7000_0000;
    localparam logic [31:0] ADDU   = 32'h3080_0000;
    localparam logic [31:0] LW     = 32'h0100_0000;
    localparam logic [31:0] SW     = 32'h1100_0000;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] IR_i;
    logic [31:0] alu_i;
    logic [31:0] store_data_i;
    logic        stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;
    logic [31:0] IR_o;
    logic [31:0] data1_o;
    logic [31:0] data2_o;
    logic        valid_o;
    logic        mem_err_o;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] d1;
        logic [31:0] d2;
    } sb_t;

    sb_t exp_q[$];
    sb_t mon_e;
    int  n_checks = 0;
    int  n_errors = 0;
    bit  mon_en   = 1'b0;

    mem_access_stage #(
        .BUBBLE_IR      (BUBBLE),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .IR_i         (IR_i),
        .alu_i        (alu_i),
        .store_data_i (store_data_i),
        .stall_o      (stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ack_i    (mem_ack_i),
        .IR_o         (IR_o),
        .data1_o      (data1_o),
        .data2_o      (data2_o),
        .valid_o      (valid_o),
        .mem_err_o    (mem_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Output monitor: valid outputs are popped from the scoreboard, everything else must be a bubble.
    always @(negedge clk_i) begin
        if (mon_en && !rst_i) begin
            if (valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", {31'd0, valid_o}, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_ir", IR_o, mon_e.ir);
                    chk("sb_data1", data1_o, mon_e.d1);
                    chk("sb_data2", data2_o, mon_e.d2);
                end
            end else begin
                chk("bubble_ir", IR_o, BUBBLE);
                chk("bubble_data1", data1_o, 32'd0);
                chk("bubble_data2", data2_o, 32'd0);
            end
        end
    end

    // Non-memory op: one cycle latency, never stalls. Called at posedge+1.
    task automatic alu_op(input logic [31:0] ir, input logic [31:0] alu);
        valid_i = 1'b1;
        IR_i    = ir;
        alu_i   = alu;
        exp_q.push_back('{ir, 32'd0, alu});
        @(negedge clk_i);
        chk("alu_stall", {31'd0, stall_o}, 32'd0);
        tick();
        valid_i = 1'b0;
    endtask

    // Memory op acked after k BUSY cycles without ack; returns at posedge+1 of the ack edge.
    task automatic mem_op(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] sd,
                          input logic [31:0] rdata, input int k);
        logic is_sw;
        is_sw        = (ir[31:28] == 4'b0001);
        valid_i      = 1'b1;
        IR_i         = ir;
        alu_i        = alu;
        store_data_i = sd;
        exp_q.push_back('{ir, is_sw ? 32'd0 : rdata, alu});
        @(negedge clk_i);
        chk("stall_accept", {31'd0, stall_o}, 32'd1);
        tick();
        chk("req_rise", {31'd0, mem_req_o}, 32'd1);
        chk("mem_we", {31'd0, mem_we_o}, {31'd0, is_sw});
        chk("mem_addr", mem_addr_o, alu);
        chk("mem_wdata", mem_wdata_o, sd);
        for (int i = 0; i < k; i++) begin
            @(negedge clk_i);
            chk("stall_busy", {31'd0, stall_o}, 32'd1);
            chk("req_hold", {31'd0, mem_req_o}, 32'd1);
            chk("addr_hold", mem_addr_o, alu);
            tick();
        end
        mem_ack_i   = 1'b1;
        mem_rdata_i = rdata;
        @(negedge clk_i);
        chk("stall_ack", {31'd0, stall_o}, 32'd0);
        tick();
        mem_ack_i   = 1'b0;
        mem_rdata_i = 32'hDEAD_BEEF;
        valid_i     = 1'b0;
        chk("req_drop", {31'd0, mem_req_o}, 32'd0);
        chk("we_drop", {31'd0, mem_we_o}, 32'd0);
    endtask

    initial begin
        rst_i        = 1'b1;
        valid_i      = 1'b0;
        IR_i         = 32'd0;
        alu_i        = 32'd0;
        store_data_i = 32'd0;
        mem_rdata_i  = 32'hDEAD_BEEF;
        mem_ack_i    = 1'b0;
        tick();
        tick();
        chk("rst_ir", IR_o, BUBBLE);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_addr", mem_addr_o, 32'd0);
        chk("rst_err", {31'd0, mem_err_o}, 32'd0);
        rst_i  = 1'b0;
        mon_en = 1'b1;
        tick();

        // ack while IDLE is ignored
        mem_ack_i = 1'b1;
        tick();
        mem_ack_i = 1'b0;

        alu_op(ADDU, 32'd5);
        tick();
        mem_op(LW, 32'h40, 32'h0, 32'hCAFE_0001, 3);
        tick();
        mem_op(SW, 32'h80, 32'h1234, 32'h5555_AAAA, 1);

        // LW followed immediately by ADDU
        mem_op(LW, 32'h44, 32'h0, 32'h0BAD_F00D, 2);
        alu_op(ADDU | 32'h7, 32'd9);
        @(negedge clk_i);
        chk("b2b_ir_prev", IR_o, ADDU | 32'h7);
        tick();

        // reset while BUSY abandons the request; a later ack produces nothing
        valid_i = 1'b1;
        IR_i    = LW;
        alu_i   = 32'h100;
        tick();
        tick();
        rst_i   = 1'b1;
        valid_i = 1'b0;
        tick();
        rst_i   = 1'b0;
        chk("rst_busy_req", {31'd0, mem_req_o}, 32'd0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h1111_2222;
        tick();
        mem_ack_i = 1'b0;
        chk("late_ack_ir", IR_o, BUBBLE);
        chk("late_ack_valid", {31'd0, valid_o}, 32'd0);
        tick();

`ifdef MEM_TIMEOUT_EN
        // LW never acked: request held 4 BUSY cycles, then aborted with sticky error
        valid_i = 1'b1;
        IR_i    = LW;
        alu_i   = 32'h200;
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("to_req_hold", {31'd0, mem_req_o}, 32'd1);
            chk("to_err_low", {31'd0, mem_err_o}, 32'd0);
            tick();
        end
        valid_i = 1'b0;
        chk("to_req_drop", {31'd0, mem_req_o}, 32'd0);
        chk("to_err_set", {31'd0, mem_err_o}, 32'd1);
        @(negedge clk_i);
        chk("to_stall_low", {31'd0, stall_o}, 32'd0);
        tick();
        alu_op(ADDU, 32'd11);
        tick();
        chk("to_err_sticky", {31'd0, mem_err_o}, 32'd1);
`else
        // Without the watchdog a long wait neither aborts nor flags an error
        mem_op(LW, 32'h300, 32'h0, 32'h7777_0001, 20);
        chk("nto_err", {31'd0, mem_err_o}, 32'd0);
        tick();
`endif

        tick();
        tick();
        mon_en = 1'b0;
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
